// File: rtl/ecc_109_enc_wr_pipe.sv
// Write-side SECDED encoder stage: duplicated parity encoders, one output register, fault status.
// Optional error injection is built when ECC_109_ENC_ERR_INJ_EN is defined.

module ecc_109_enc_core #(
   parameter int DATA_WIDTH   = 109,
   parameter int PARITY_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]   data,
   output logic [PARITY_WIDTH-1:0] parity
);

   logic [PARITY_WIDTH-2:0] ham;
   logic [31:0]             pos;

   // Data bits occupy codeword positions from 3 upward, skipping powers of two.
   always_comb begin
      ham = '0;
      pos = 32'd3;
      for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
         if ((pos & (pos - 32'd1)) == 32'd0) pos = pos + 32'd1;
         for (int unsigned i = 0; i < PARITY_WIDTH - 1; i++) begin
            if (pos[i]) ham[i] = ham[i] ^ data[k];
         end
         pos = pos + 32'd1;
      end
      parity = {(^data) ^ (^ham), ham};
   end

endmodule

module ecc_109_enc_wr_pipe #(
   parameter int DATA_WIDTH   = 109,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    bypass,
   input  logic                    ecc_fault_detc_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [PARITY_WIDTH-1:0] out_parity,
   output logic                    out_fault,
   output logic                    fault_sticky,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   input  logic                    fault_clr,
   input  logic                    inj_sbit,
   input  logic                    inj_dbit,
   output logic                    inj_pending
);

   (* keep = "true" *) logic [PARITY_WIDTH-1:0] parity0;
   (* keep = "true" *) logic [PARITY_WIDTH-1:0] parity1;
   logic                  accept;
   logic                  mismatch;
   logic [DATA_WIDTH-1:0] inj_flip;

   (* keep_hierarchy = "yes" *)
   ecc_109_enc_core #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_copy0 (
      .data   (in_data),
      .parity (parity0)
   );

   (* keep_hierarchy = "yes" *)
   ecc_109_enc_core #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_copy1 (
      .data   (in_data),
      .parity (parity1)
   );

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign mismatch = ecc_fault_detc_en & ~bypass & (parity0 != parity1);

`ifdef ECC_109_ENC_ERR_INJ_EN
   logic       inj_armed;
   logic [1:0] inj_mask;

   // An arm pulse in the accept cycle re-arms for the following beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_armed <= 1'b0;
         inj_mask  <= 2'b00;
      end else begin
         if (accept) inj_armed <= 1'b0;
         if (inj_sbit | inj_dbit) begin
            inj_armed <= 1'b1;
            inj_mask  <= inj_dbit ? 2'b11 : 2'b01;
         end
      end
   end

   assign inj_flip    = {{(DATA_WIDTH-2){1'b0}}, (inj_armed ? inj_mask : 2'b00)};
   assign inj_pending = inj_armed;
`else
   logic unused_inj;

   assign unused_inj  = inj_sbit ^ inj_dbit;
   assign inj_flip    = '0;
   assign inj_pending = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_parity <= '0;
         out_fault  <= 1'b0;
      end else begin
         if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data ^ inj_flip;
            out_parity <= bypass ? '0 : parity0;
            out_fault  <= mismatch;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_sticky <= 1'b0;
         fault_cnt    <= '0;
      end else if (fault_clr) begin
         fault_sticky <= 1'b0;
         fault_cnt    <= '0;
      end else if (accept && mismatch) begin
         fault_sticky <= 1'b1;
         if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_109_enc_wr_pipe.sv
// Directed self-checking bench for ecc_109_enc_wr_pipe; expected parities are hand-computed.

module tb_ecc_109_enc_wr_pipe;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [108:0] in_data;
   logic         bypass;
   logic         ecc_fault_detc_en;
   logic         out_valid;
   logic         out_ready;
   logic [108:0] out_data;
   logic [7:0]   out_parity;
   logic         out_fault;
   logic         fault_sticky;
   logic [7:0]   fault_cnt;
   logic         fault_clr;
   logic         inj_sbit;
   logic         inj_dbit;
   logic         inj_pending;

   int checks = 0;
   int errors = 0;

   logic [108:0] vec_data [8];
   logic [7:0]   vec_par  [8];
   logic         inj_on;

   always #5 clk = ~clk;

   ecc_109_enc_wr_pipe #(.DATA_WIDTH(109), .PARITY_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .bypass            (bypass),
      .ecc_fault_detc_en (ecc_fault_detc_en),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_parity        (out_parity),
      .out_fault         (out_fault),
      .fault_sticky      (fault_sticky),
      .fault_cnt         (fault_cnt),
      .fault_clr         (fault_clr),
      .inj_sbit          (inj_sbit),
      .inj_dbit          (inj_dbit),
      .inj_pending       (inj_pending)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef ECC_109_ENC_ERR_INJ_EN
      inj_on = 1'b1;
`else
      inj_on = 1'b0;
`endif
      // single-bit data vectors: bit k at position p, parity = {1^popcount(p), p}
      vec_data[0] = '0;         vec_par[0] = 8'h00;
      vec_data[1] = 109'd1;     vec_par[1] = 8'h83;
      vec_data[2] = 109'd2;     vec_par[2] = 8'h85;
      vec_data[3] = 109'd3;     vec_par[3] = 8'h06;
      vec_data[4] = 109'd4;     vec_par[4] = 8'h86;
      vec_data[5] = 109'd8;     vec_par[5] = 8'h07;
      vec_data[6] = 109'd16;    vec_par[6] = 8'h89;
      vec_data[7] = '0;         vec_par[7] = 8'hF4;
      vec_data[7][108] = 1'b1;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bypass = 1'b0;
      ecc_fault_detc_en = 1'b1; out_ready = 1'b0; fault_clr = 1'b0;
      inj_sbit = 1'b0; inj_dbit = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_parity", out_parity, 0);
      check("rst_out_fault", out_fault, 0);
      check("rst_sticky", fault_sticky, 0);
      check("rst_cnt", fault_cnt, 0);
      check("rst_inj_pending", inj_pending, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("post_rst_in_ready", in_ready, 1);

      // basic encodes
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vec_data[i];
         step();
         check("basic_valid", out_valid, 1);
         check("basic_data", out_data, vec_data[i]);
         check("basic_parity", out_parity, vec_par[i]);
         check("basic_fault", out_fault, 0);
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", out_valid, 0);

      // back-to-back stream then stall
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = vec_data[i];
         step();
         check("stream_valid", out_valid, 1);
         check("stream_data", out_data, vec_data[i]);
         check("stream_parity", out_parity, vec_par[i]);
      end
      out_ready = 1'b0; in_valid = 1'b1; in_data = vec_data[1];
      #1;
      check("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, vec_data[7]);
         check("stall_parity", out_parity, 8'hF4);
         check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", in_ready, 1);
      step();
      check("unstall_data", out_data, vec_data[1]);
      check("unstall_parity", out_parity, 8'h83);
      in_valid = 1'b0;
      step();
      check("unstall_drain", out_valid, 0);

      // forced copy mismatch on parity[3]
      force dut.parity1 = 8'h08;
      in_data = '0; in_valid = 1'b1;
      step();
      check("fault_beat0", out_fault, 1);
      step();
      check("fault_beat1", out_fault, 1);
      check("fault_data_clean", out_data, 0);
      check("fault_sticky", fault_sticky, 1);
      check("fault_cnt2", fault_cnt, 2);
      ecc_fault_detc_en = 1'b0;
      step();
      check("dis_fault0", out_fault, 0);
      step();
      check("dis_fault1", out_fault, 0);
      check("dis_cnt", fault_cnt, 2);
      ecc_fault_detc_en = 1'b1;

      // saturation and clear priority
      in_valid = 1'b0; fault_clr = 1'b1;
      step();
      check("clr_cnt", fault_cnt, 0);
      check("clr_sticky", fault_sticky, 0);
      fault_clr = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 300; i++) step();
      check("sat_cnt", fault_cnt, 255);
      check("sat_sticky", fault_sticky, 1);
      fault_clr = 1'b1;
      step();
      check("clr_prio_cnt", fault_cnt, 0);
      check("clr_prio_sticky", fault_sticky, 0);
      fault_clr = 1'b0;

      // bypass under forced mismatch
      force dut.parity1 = 8'h8B;
      bypass = 1'b1; in_data = vec_data[1];
      step();
      check("bypass_parity", out_parity, 0);
      check("bypass_fault", out_fault, 0);
      check("bypass_data", out_data, 1);
      check("bypass_cnt", fault_cnt, 0);
      release dut.parity1;
      bypass = 1'b0; in_valid = 1'b0;
      step();

      // error injection
      inj_dbit = 1'b1;
      step();
      inj_dbit = 1'b0;
      check("inj_armed", inj_pending, inj_on);
      in_data = '0; in_valid = 1'b1;
      step();
      check("inj_dbit_data", out_data, inj_on ? 3 : 0);
      check("inj_dbit_parity", out_parity, 0);
      check("inj_cleared", inj_pending, 0);
      inj_sbit = 1'b1;
      step();
      inj_sbit = 1'b0;
      check("inj_oneshot", out_data, 0);
      check("inj_rearm", inj_pending, inj_on);
      step();
      check("inj_next_beat", out_data, inj_on ? 1 : 0);
      in_valid = 1'b0;
      step();

      // reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; in_data = vec_data[2];
      step();
      check("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_data", out_data, 0);
      check("midrst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_109_enc_wr_pipe.md
# ecc_109_enc_wr_pipe

Write-side SECDED encoder stage for the 109-bit FIFO data path. It accepts 109-bit data beats on a valid/ready handshake and computes the 8-bit parity with two redundant encoder copies. Parity is registered alongside the data with one cycle of latency. A mismatch between the two encoder copies is reported as an encoder fault, both per beat and as sticky/counted status. It sits in front of the FIFO write port and produces the codeword that the read-side ECC check later verifies.

## Interface
- DATA_WIDTH, 109, data bits per beat
- PARITY_WIDTH, 8, parity bits (7 Hamming + 1 overall)
- CNT_WIDTH, 8, width of saturating fault counter

- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- in_data  input  DATA_WIDTH  data to encode
- bypass  input  1  sampled per beat; parity forced to 0, compare disabled
- ecc_fault_detc_en  input  1  enables redundant-copy compare
- out_valid  output  1  codeword valid
- out_ready  input  1  downstream accepts codeword
- out_data  output  DATA_WIDTH  registered data
- out_parity  output  PARITY_WIDTH  registered parity
- out_fault  output  1  this beat had an encoder mismatch
- fault_sticky  output  1  set on any fault, held until cleared
- fault_cnt  output  CNT_WIDTH  saturating count of faulty beats
- fault_clr  input  1  synchronous clear of fault_sticky and fault_cnt
- inj_sbit  input  1  error injection: arm single-bit flip (pulse)
- inj_dbit  input  1  error injection: arm double-bit flip (pulse)
- inj_pending  output  1  an injection is armed

## Operation
- Code: data bit k maps to codeword position p(k), the (k+1)-th integer ≥3 that is not a power of two (data[0]→3, data[1]→5, data[108]→116).
- Code: parity[i] (i=0..6) = XOR of data[k] for which bit i of p(k) is set.
- Code: parity[7] = XOR of all data bits and parity[6:0].
- Two independent encoder instances (copy0, copy1) evaluate in_data combinationally. Both must be kept against synthesis merging (preserve attribute).
- mismatch = ecc_fault_detc_en & ~bypass & (parity0 != parity1).
- On accept (in_valid & in_ready), the output register loads out_data=in_data, out_parity = bypass ? 0 : parity0, out_fault=mismatch.
- Data is never altered by a fault; out_fault is the sideband poison indication.
- in_ready = ~out_valid | out_ready (single output register, full throughput).
- out_valid sets on accept and clears on out_ready when no new accept occurs.
- fault_sticky/fault_cnt update on the accept cycle with mismatch. The counter saturates at 2^CNT_WIDTH-1.
- fault_clr has priority over a same-cycle increment; after the clear, sticky=0 and cnt=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_parity=0, out_fault=0, fault_sticky=0, fault_cnt=0, inj_pending=0. in_ready=1 during and after reset.
- Latency: an accepted beat appears on out_* on the next clock edge.
- When out_valid & ~out_ready, out_* hold stable and in_ready=0.
- Simultaneous drain and accept: the register is replaced, with no bubble.
- Reset mid-stream drops the held beat. No partial state survives.

## Configuration
- Macro ECC_109_ENC_ERR_INJ_EN.
- Defined: inj_sbit arms a one-shot flip of out_data[0], and inj_dbit arms a flip of out_data[1:0]. If both are pulsed, dbit wins.
- Defined: the flip applies to the next accepted beat after parity is computed, so parity stays clean. inj_pending=1 from the cycle after the arm until that accept, then clears.
- Defined: an arm pulse during the accept cycle applies to the following beat.
- Not defined: inj_* inputs are ignored, inj_pending is tied 0, and no injection logic is synthesized.

## Test plan
- in_data=0 → out_parity=0x00. in_data=1 → 0x83. in_data=2 → 0x85. Each appears one cycle after accept, with out_fault=0.
- Stream 8 back-to-back beats with out_ready=1, then hold out_ready=0 for 3 cycles → no beat lost or duplicated; in_ready=0 while stalled; out_* stable.
- Force copy1 parity[3] inverted with ecc_fault_detc_en=1 for 2 beats → out_fault=1 on both beats, fault_sticky=1, fault_cnt=2. The same with enable=0 → no fault.
- Fault on 300 beats with CNT_WIDTH=8 → fault_cnt saturates at 255. fault_clr together with a fault → sticky=0, cnt=0.
- bypass=1, in_data=1 → out_parity=0x00 with out_fault=0 even under a forced mismatch.
- With the macro defined, pulse inj_dbit and then send in_data=0 → out_data=0x3, out_parity=0x00, inj_pending drops after the accept. Without the macro → out_data=0.
